// File: rtl/exception_unit_if.sv
// Exception unit bus: memory-stage request inputs from the pipeline and
// CP0 capture / flush / redirect outputs back to the pipeline.
interface exception_unit_if;
  logic        run;
  logic [9:0]  req;
  logic        eret_req;
  logic [31:0] pc_m;
  logic        ds_m;
  logic [31:0] va_m;
  logic        exc_level;
  logic [31:0] epc_q;
  logic        e_enter;
  logic        eret;
  logic [4:0]  cause;
  logic [31:0] epc;
  logic [31:0] bad_va;
  logic        delay_slot;
  logic        flush;
  logic        redirect;
  logic [31:0] redirect_pc;

  // pipeline / CP0 side
  modport master (
    output run, req, eret_req, pc_m, ds_m, va_m, exc_level, epc_q,
    input  e_enter, eret, cause, epc, bad_va, delay_slot, flush, redirect, redirect_pc
  );

  // exception unit side
  modport slave (
    input  run, req, eret_req, pc_m, ds_m, va_m, exc_level, epc_q,
    output e_enter, eret, cause, epc, bad_va, delay_slot, flush, redirect, redirect_pc
  );
endinterface

// File: rtl/exception_unit.sv
// exception_unit: samples exception/ERET requests at the memory stage, picks
// the highest-priority cause, strobes CP0 capture, then flushes the pipeline
// and redirects the PC to the exception vector (or EPC on ERET).
// Optional: EXC_TLB_REFILL_VEC_EN sends TLB causes taken at EXC_LEVEL=0 to
// the refill vector at VECTOR_BASE+0.
module exception_unit #(
  parameter logic [31:0] VECTOR_BASE  = 32'h8000_0000,
  parameter int          FLUSH_CYCLES = 3
) (
  input logic            clk,
  input logic            reset_n,
  exception_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DRAIN, REDIR} state_t;

  state_t      state, next_state;
  logic [3:0]  cnt, cnt_nxt;

  logic        win_va;      // winning cause latches BAD_VA
  logic        win_tlb;     // winning cause is a TLB miss
  logic [4:0]  win_code;
  logic        exc_hit, eret_hit, start_exc, start_eret;
  logic [31:0] exc_target;
  logic [31:0] tgt_q;

  logic        e_enter_q, eret_q, delay_slot_q, flush_q, redirect_q;
  logic [4:0]  cause_q;
  logic [31:0] epc_r, bad_va_q, redirect_pc_q;

  // Priority encode: lowest REQ index among [8:0] wins; REQ[9] only picks
  // the store flavour of the data address / TLB causes.
  always_comb begin
    win_code = 5'd0;
    win_va   = 1'b0;
    win_tlb  = 1'b0;
    if      (bus.req[0]) win_code = 5'd0;
    else if (bus.req[1]) begin win_code = 5'd4; win_va = 1'b1; end
    else if (bus.req[2]) begin win_code = 5'd2; win_va = 1'b1; win_tlb = 1'b1; end
    else if (bus.req[3]) win_code = 5'd10;
    else if (bus.req[4]) win_code = 5'd8;
    else if (bus.req[5]) win_code = 5'd9;
    else if (bus.req[6]) win_code = 5'd12;
    else if (bus.req[7]) begin
      win_code = bus.req[9] ? 5'd5 : 5'd4;
      win_va   = 1'b1;
    end else if (bus.req[8]) begin
      win_code = bus.req[9] ? 5'd3 : 5'd2;
      win_va   = 1'b1;
      win_tlb  = 1'b1;
    end
  end

  assign exc_hit    = bus.run & (|bus.req[8:0]);
  assign eret_hit   = bus.run & bus.eret_req & ~(|bus.req[8:0]);
  assign start_exc  = (state == IDLE) & exc_hit;
  assign start_eret = (state == IDLE) & eret_hit;

`ifdef EXC_TLB_REFILL_VEC_EN
  assign exc_target = (win_tlb && !bus.exc_level) ? VECTOR_BASE
                                                  : VECTOR_BASE + 32'h180;
`else
  // exc_level and win_tlb only matter for the refill vector
  assign exc_target = VECTOR_BASE + 32'h180;
`endif

  // Next-state: DRAIN counts FLUSH_CYCLES cycles regardless of RUN, then one
  // REDIR cycle; requests outside IDLE are dropped.
  always_comb begin
    next_state = state;
    cnt_nxt    = cnt;
    case (state)
      IDLE: if (start_exc || start_eret) begin
        next_state = DRAIN;
        cnt_nxt    = 4'(FLUSH_CYCLES - 1);
      end
      DRAIN: if (cnt == 4'd0) next_state = REDIR;
             else             cnt_nxt    = cnt - 4'd1;
      REDIR: next_state = IDLE;
      default: begin
        next_state = IDLE;
        cnt_nxt    = 4'd0;
      end
    endcase
  end

  // State register and counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= next_state;
      cnt   <= cnt_nxt;
    end
  end

  // Strobes and flush/redirect levels, registered from the next state so
  // they line up with the cycle the state is entered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      e_enter_q  <= 1'b0;
      eret_q     <= 1'b0;
      flush_q    <= 1'b0;
      redirect_q <= 1'b0;
    end else begin
      e_enter_q  <= start_exc;
      eret_q     <= start_eret;
      flush_q    <= (next_state != IDLE);
      redirect_q <= (next_state == REDIR);
    end
  end

  // CP0 capture fields; held between exceptions, BAD_VA only for address causes
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cause_q      <= 5'd0;
      epc_r        <= 32'd0;
      bad_va_q     <= 32'd0;
      delay_slot_q <= 1'b0;
    end else if (start_exc) begin
      cause_q      <= win_code;
      epc_r        <= bus.ds_m ? bus.pc_m - 32'd4 : bus.pc_m;
      delay_slot_q <= bus.ds_m;
      if (win_va) bad_va_q <= bus.va_m;
    end
  end

  // Redirect target latched at trigger, published when REDIR is entered
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tgt_q         <= 32'd0;
      redirect_pc_q <= 32'd0;
    end else begin
      if (start_exc)       tgt_q <= exc_target;
      else if (start_eret) tgt_q <= bus.epc_q;
      if (next_state == REDIR) redirect_pc_q <= tgt_q;
    end
  end

  assign bus.e_enter     = e_enter_q;
  assign bus.eret        = eret_q;
  assign bus.cause       = cause_q;
  assign bus.epc         = epc_r;
  assign bus.bad_va      = bad_va_q;
  assign bus.delay_slot  = delay_slot_q;
  assign bus.flush       = flush_q;
  assign bus.redirect    = redirect_q;
  assign bus.redirect_pc = redirect_pc_q;

endmodule

// File: tb/tb_exception_unit.sv
// Directed bench for exception_unit (FLUSH_CYCLES=3, VECTOR_BASE=8000_0000).
module tb_exception_unit;
  logic clk = 1'b0;
  logic reset_n;
  int   n_vec = 0;
  int   n_err = 0;

  exception_unit_if bus ();

  exception_unit #(.VECTOR_BASE(32'h8000_0000), .FLUSH_CYCLES(3)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // After the T+1 checks: T+2, T+3 drain; T+4 redirect; T+5 idle with PC held
  task automatic tail(input string tag, input logic [31:0] pc);
    tick();
    chk({tag, " t2 flush"}, 32'(bus.flush), 32'd1);
    chk({tag, " t2 strobes"}, {29'd0, bus.e_enter, bus.eret, bus.redirect}, 32'd0);
    tick();
    chk({tag, " t3 flush/redir"}, {30'd0, bus.flush, bus.redirect}, 32'b10);
    tick();
    chk({tag, " t4 flush/redir"}, {30'd0, bus.flush, bus.redirect}, 32'b11);
    chk({tag, " t4 redirect_pc"}, bus.redirect_pc, pc);
    tick();
    chk({tag, " t5 flush/redir"}, {30'd0, bus.flush, bus.redirect}, 32'b00);
    chk({tag, " t5 pc hold"}, bus.redirect_pc, pc);
  endtask

  initial begin
    reset_n = 1'b0;
    bus.run = 1'b0; bus.req = '0; bus.eret_req = 1'b0; bus.pc_m = '0;
    bus.ds_m = 1'b0; bus.va_m = '0; bus.exc_level = 1'b0; bus.epc_q = '0;
    tick(); tick();
    chk("rst strobes", {27'd0, bus.e_enter, bus.eret, bus.flush, bus.redirect, bus.delay_slot}, 32'd0);
    chk("rst cause", 32'(bus.cause), 32'd0);
    chk("rst epc", bus.epc, 32'd0);
    chk("rst bad_va", bus.bad_va, 32'd0);
    chk("rst redirect_pc", bus.redirect_pc, 32'd0);
    reset_n = 1'b1;
    tick();

    // 1: overflow
    bus.run = 1'b1; bus.req = 10'h040; bus.pc_m = 32'h0040_0010;
    tick();
    bus.req = '0;
    chk("t1 e_enter/eret/flush", {29'd0, bus.e_enter, bus.eret, bus.flush}, 32'b101);
    chk("t1 cause", 32'(bus.cause), 32'd12);
    chk("t1 epc", bus.epc, 32'h0040_0010);
    chk("t1 bad_va hold", bus.bad_va, 32'd0);
    tail("t1", 32'h8000_0180);

    // 2: TLB store miss in delay slot
    bus.req = 10'h300; bus.va_m = 32'h1234_5678; bus.ds_m = 1'b1;
    bus.pc_m = 32'h0040_0024; bus.exc_level = 1'b0;
    tick();
    bus.req = '0; bus.ds_m = 1'b0;
    chk("t2 cause", 32'(bus.cause), 32'd3);
    chk("t2 bad_va", bus.bad_va, 32'h1234_5678);
    chk("t2 epc", bus.epc, 32'h0040_0020);
    chk("t2 delay_slot", 32'(bus.delay_slot), 32'd1);
`ifdef EXC_TLB_REFILL_VEC_EN
    tail("t2", 32'h8000_0000);
`else
    tail("t2", 32'h8000_0180);
`endif

    // 3: INT beats SYS, BAD_VA untouched
    bus.req = 10'h011; bus.va_m = 32'hDEAD_BEEF; bus.pc_m = 32'h0040_0030;
    tick();
    bus.req = '0;
    chk("t3 cause", 32'(bus.cause), 32'd0);
    chk("t3 bad_va hold", bus.bad_va, 32'h1234_5678);
    chk("t3 delay_slot", 32'(bus.delay_slot), 32'd0);
    tail("t3", 32'h8000_0180);

    // 4a: ERET alone
    bus.eret_req = 1'b1; bus.epc_q = 32'h0040_0100;
    tick();
    bus.eret_req = 1'b0;
    chk("t4a e_enter/eret/flush", {29'd0, bus.e_enter, bus.eret, bus.flush}, 32'b011);
    chk("t4a cause hold", 32'(bus.cause), 32'd0);
    tail("t4a", 32'h0040_0100);

    // 4b: RI beats ERET
    bus.eret_req = 1'b1; bus.req = 10'h008; bus.pc_m = 32'h0040_0040;
    tick();
    bus.eret_req = 1'b0; bus.req = '0;
    chk("t4b e_enter/eret/flush", {29'd0, bus.e_enter, bus.eret, bus.flush}, 32'b101);
    chk("t4b cause", 32'(bus.cause), 32'd10);
    tail("t4b", 32'h8000_0180);

    // 5: stalled pipeline ignores requests; DRAIN ignores new ones
    bus.run = 1'b0; bus.req = 10'h010;
    tick(); tick();
    chk("t5 stalled", {30'd0, bus.e_enter, bus.flush}, 32'd0);
    bus.run = 1'b1;
    tick();
    bus.req = 10'h001;
    chk("t5 e_enter", 32'(bus.e_enter), 32'd1);
    chk("t5 cause", 32'(bus.cause), 32'd8);
    tick();
    chk("t5 drain no e_enter", 32'(bus.e_enter), 32'd0);
    tick();
    chk("t5 drain cause hold", 32'(bus.cause), 32'd8);
    tick();
    bus.req = '0;
    chk("t5 redirect", {30'd0, bus.e_enter, bus.redirect}, 32'b01);
    tick();
    chk("t5 after", {29'd0, bus.e_enter, bus.flush, bus.redirect}, 32'd0);
    chk("t5 cause final", 32'(bus.cause), 32'd8);

    // 6: reset mid-DRAIN abandons the sequence
    bus.req = 10'h004; bus.va_m = 32'h0000_BAD0; bus.pc_m = 32'h0040_0200;
    tick();
    bus.req = '0;
    chk("t6 cause", 32'(bus.cause), 32'd2);
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    chk("t6 rst strobes", {27'd0, bus.e_enter, bus.eret, bus.flush, bus.redirect, bus.delay_slot}, 32'd0);
    chk("t6 rst cause", 32'(bus.cause), 32'd0);
    chk("t6 rst epc/bad_va", bus.epc | bus.bad_va, 32'd0);
    chk("t6 rst redirect_pc", bus.redirect_pc, 32'd0);
    tick(); tick(); tick();
    chk("t6 no redirect", {30'd0, bus.flush, bus.redirect}, 32'd0);
    bus.req = 10'h040; bus.pc_m = 32'h0040_0300;
    tick();
    bus.req = '0;
    chk("t6 post e_enter/flush", {30'd0, bus.e_enter, bus.flush}, 32'b11);
    chk("t6 post cause", 32'(bus.cause), 32'd12);
    chk("t6 post epc", bus.epc, 32'h0040_0300);
    tail("t6", 32'h8000_0180);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Timeout guard
  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
